// File: rtl/reservation_station.sv
// Reservation station: holds renamed instructions until both operands are ready, then issues one per cycle.
// Optional macro RS_AGE_SELECT_EN: oldest-ready selection via per-entry saturating age counters.

package rs_pkg;
    typedef enum logic [4:0] {
        INSTR_NOP, INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR, INSTR_BEQ, INSTR_BNE,
        INSTR_BLT, INSTR_BGE, INSTR_LW, INSTR_SW, INSTR_ADD, INSTR_SUB, INSTR_AND,
        INSTR_OR, INSTR_XOR, INSTR_SLL, INSTR_SRL, INSTR_SRA, INSTR_SLT, INSTR_ADDI
    } instr_name_e;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_address,
    input  logic [XLEN-1:0]            in_immediate,
    input  instr_name_e                in_instr_name,
    input  logic [5:0]                 in_src_1,
    input  logic [5:0]                 in_src_2,
    input  logic [XLEN-1:0]            in_data_1,
    input  logic [XLEN-1:0]            in_data_2,
    input  logic                       in_rdy_1,
    input  logic                       in_rdy_2,
    input  logic [5:0]                 in_rrn,
    input  logic                       cdb_valid,
    input  logic [5:0]                 cdb_rrn,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_address,
    output logic [XLEN-1:0]            out_immediate,
    output logic [XLEN-1:0]            out_data_1,
    output logic [XLEN-1:0]            out_data_2,
    output instr_name_e                out_instr_name,
    output logic [5:0]                 out_rrn,
    output logic [$clog2(DEPTH):0]     free_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_rdy_1;
    logic [DEPTH-1:0] ent_rdy_2;
    logic [XLEN-1:0]  ent_address   [DEPTH];
    logic [XLEN-1:0]  ent_immediate [DEPTH];
    logic [XLEN-1:0]  ent_data_1    [DEPTH];
    logic [XLEN-1:0]  ent_data_2    [DEPTH];
    logic [5:0]       ent_src_1     [DEPTH];
    logic [5:0]       ent_src_2     [DEPTH];
    logic [5:0]       ent_rrn       [DEPTH];
    instr_name_e      ent_instr_name[DEPTH];

    logic [DEPTH-1:0] ready_vec;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    ins_idx;
    logic             sel_found;
    logic [CW-1:0]    free_cnt;
    logic             do_issue;
    logic             do_insert;
    logic             cdb_live;
    logic [XLEN:0]    ins_op_1;
    logic [XLEN:0]    ins_op_2;

    // Operand at insert: x0 reads as zero, a same-cycle CDB broadcast beats the regfile value.
    function automatic logic [XLEN:0] insert_operand(input logic [5:0] src, input logic [XLEN-1:0] data,
                                                     input logic rdy, input logic bcast,
                                                     input logic [5:0] btag, input logic [XLEN-1:0] bdata);
        logic [XLEN:0] result;
        if (src == 6'd0)
            result = {1'b1, {XLEN{1'b0}}};
        else if (bcast && btag == src)
            result = {1'b1, bdata};
        else
            result = {rdy, data};
        return result;
    endfunction

    assign cdb_live  = cdb_valid && (cdb_rrn != 6'd0);
    assign ins_op_1  = insert_operand(in_src_1, in_data_1, in_rdy_1, cdb_valid, cdb_rrn, cdb_data);
    assign ins_op_2  = insert_operand(in_src_2, in_data_2, in_rdy_2, cdb_valid, cdb_rrn, cdb_data);
    assign ready_vec = ent_valid & ent_rdy_1 & ent_rdy_2;
    assign free_count = free_cnt;
    assign in_ready   = (free_cnt != '0);
    assign do_insert  = in_valid && in_ready && !flush;
    assign do_issue   = sel_found && (!out_valid || out_ready) && !flush;

    always_comb begin
        free_cnt = '0;
        ins_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_cnt = free_cnt + CW'(!ent_valid[i]);
            if (!ent_valid[i])
                ins_idx = IW'(i);
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [IW-1:0] ent_age [DEPTH];
    logic [IW-1:0] best_age;

    // Strict greater-than keeps ties on the lowest index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_vec[i] && (!sel_found || ent_age[i] > best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                best_age  = ent_age[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                ent_age[i] <= '0;
        end else if (do_insert) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IW'(i) == ins_idx)
                    ent_age[i] <= '0;
                else if (ent_valid[i] && ent_age[i] != '1)
                    ent_age[i] <= ent_age[i] + 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid <= '0;
            ent_rdy_1 <= '0;
            ent_rdy_2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_address[i]    <= '0;
                ent_immediate[i]  <= '0;
                ent_data_1[i]     <= '0;
                ent_data_2[i]     <= '0;
                ent_src_1[i]      <= '0;
                ent_src_2[i]      <= '0;
                ent_rrn[i]        <= '0;
                ent_instr_name[i] <= INSTR_NOP;
            end
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && cdb_live) begin
                    if (!ent_rdy_1[i] && ent_src_1[i] == cdb_rrn) begin
                        ent_rdy_1[i]  <= 1'b1;
                        ent_data_1[i] <= cdb_data;
                    end
                    if (!ent_rdy_2[i] && ent_src_2[i] == cdb_rrn) begin
                        ent_rdy_2[i]  <= 1'b1;
                        ent_data_2[i] <= cdb_data;
                    end
                end
            end
            if (do_issue)
                ent_valid[sel_idx] <= 1'b0;
            // The insert slot was free in the registered state, so it never collides with the issue slot.
            if (do_insert) begin
                ent_valid[ins_idx]      <= 1'b1;
                ent_address[ins_idx]    <= in_address;
                ent_immediate[ins_idx]  <= in_immediate;
                ent_instr_name[ins_idx] <= in_instr_name;
                ent_src_1[ins_idx]      <= in_src_1;
                ent_src_2[ins_idx]      <= in_src_2;
                ent_rdy_1[ins_idx]      <= ins_op_1[XLEN];
                ent_rdy_2[ins_idx]      <= ins_op_2[XLEN];
                ent_data_1[ins_idx]     <= ins_op_1[XLEN-1:0];
                ent_data_2[ins_idx]     <= ins_op_2[XLEN-1:0];
                ent_rrn[ins_idx]        <= in_rrn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_address    <= '0;
            out_immediate  <= '0;
            out_data_1     <= '0;
            out_data_2     <= '0;
            out_instr_name <= INSTR_NOP;
            out_rrn        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (do_issue) begin
            out_valid      <= 1'b1;
            out_address    <= ent_address[sel_idx];
            out_immediate  <= ent_immediate[sel_idx];
            out_data_1     <= ent_data_1[sel_idx];
            out_data_2     <= ent_data_2[sel_idx];
            out_instr_name <= ent_instr_name[sel_idx];
            out_rrn        <= ent_rrn[sel_idx];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    insert_while_full: assert property (@(posedge clk) disable iff (!reset_n) in_valid |-> in_ready);
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus randomized traffic
// compared every cycle against an entry-list reference model.
`timescale 1ns/1ps
module tb_reservation_station;
    import rs_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   in_address = '0;
    logic [XLEN-1:0]   in_immediate = '0;
    instr_name_e       in_instr_name = INSTR_NOP;
    logic [5:0]        in_src_1 = '0;
    logic [5:0]        in_src_2 = '0;
    logic [XLEN-1:0]   in_data_1 = '0;
    logic [XLEN-1:0]   in_data_2 = '0;
    logic              in_rdy_1 = 1'b0;
    logic              in_rdy_2 = 1'b0;
    logic [5:0]        in_rrn = '0;
    logic              cdb_valid = 1'b0;
    logic [5:0]        cdb_rrn = '0;
    logic [XLEN-1:0]   cdb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_address;
    logic [XLEN-1:0]   out_immediate;
    logic [XLEN-1:0]   out_data_1;
    logic [XLEN-1:0]   out_data_2;
    instr_name_e       out_instr_name;
    logic [5:0]        out_rrn;
    logic [2:0]        free_count;

    always #5 clk = ~clk;

    reservation_station #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_address(in_address), .in_immediate(in_immediate), .in_instr_name(in_instr_name),
        .in_src_1(in_src_1), .in_src_2(in_src_2), .in_data_1(in_data_1), .in_data_2(in_data_2),
        .in_rdy_1(in_rdy_1), .in_rdy_2(in_rdy_2), .in_rrn(in_rrn),
        .cdb_valid(cdb_valid), .cdb_rrn(cdb_rrn), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_address(out_address), .out_immediate(out_immediate),
        .out_data_1(out_data_1), .out_data_2(out_data_2),
        .out_instr_name(out_instr_name), .out_rrn(out_rrn), .free_count(free_count)
    );

    // Reference model: a slot table where each instruction remembers its insertion sequence number.
    typedef struct {
        bit          v;
        logic [31:0] addr;
        logic [31:0] imm;
        instr_name_e name;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          r1;
        bit          r2;
        logic [5:0]  rrn;
        int          seq;
    } ent_t;

    ent_t m_ent [DEPTH];
    ent_t m_out;
    bit   m_out_v;
    int   m_ins_count;
    int   checks = 0;
    int   passes = 0;

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (!m_ent[i].v) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < DEPTH; i++)
            if (!m_ent[i].v) return i;
        return -1;
    endfunction

    // Age = inserts seen since this one, capped at DEPTH-1; without age selection all ages tie.
    function automatic int m_pick();
        int best = -1;
        int best_age = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) begin
`ifdef RS_AGE_SELECT_EN
                int age = m_ins_count - m_ent[i].seq - 1;
                if (age > DEPTH - 1) age = DEPTH - 1;
`else
                int age = 0;
`endif
                if (age > best_age) begin
                    best = i;
                    best_age = age;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) m_ent[i].v = 1'b0;
            m_out_v = 1'b0;
            m_ins_count = 0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_ent[i].v = 1'b0;
            m_out_v = 1'b0;
        end else begin
            int ins;
            int sel;
            ins = m_lowest_free();
            sel = m_pick();
            if (sel >= 0 && (!m_out_v || out_ready)) begin
                m_out = m_ent[sel];
                m_out_v = 1'b1;
                m_ent[sel].v = 1'b0;
            end else if (out_ready) begin
                m_out_v = 1'b0;
            end
            if (cdb_valid && cdb_rrn != 6'd0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_ent[i].v && !m_ent[i].r1 && m_ent[i].s1 == cdb_rrn) begin
                        m_ent[i].r1 = 1'b1; m_ent[i].d1 = cdb_data;
                    end
                    if (m_ent[i].v && !m_ent[i].r2 && m_ent[i].s2 == cdb_rrn) begin
                        m_ent[i].r2 = 1'b1; m_ent[i].d2 = cdb_data;
                    end
                end
            end
            if (in_valid && ins >= 0) begin
                ent_t e;
                e.v = 1'b1; e.addr = in_address; e.imm = in_immediate; e.name = in_instr_name;
                e.s1 = in_src_1; e.s2 = in_src_2; e.rrn = in_rrn; e.seq = m_ins_count;
                e.r1 = in_rdy_1; e.d1 = in_data_1;
                e.r2 = in_rdy_2; e.d2 = in_data_2;
                if (cdb_valid && cdb_rrn == in_src_1) begin e.r1 = 1'b1; e.d1 = cdb_data; end
                if (cdb_valid && cdb_rrn == in_src_2) begin e.r2 = 1'b1; e.d2 = cdb_data; end
                if (in_src_1 == 6'd0) begin e.r1 = 1'b1; e.d1 = '0; end
                if (in_src_2 == 6'd0) begin e.r2 = 1'b1; e.d2 = '0; end
                m_ent[ins] = e;
                m_ins_count++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected)
            passes++;
        else
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic compareModel();
        checkOutput("m_out_valid", out_valid, m_out_v);
        checkOutput("m_in_ready", in_ready, m_free() != 0);
        checkOutput("m_free_count", free_count, m_free());
        if (m_out_v) begin
            checkOutput("m_out_rrn", out_rrn, m_out.rrn);
            checkOutput("m_out_data_1", out_data_1, m_out.d1);
            checkOutput("m_out_data_2", out_data_2, m_out.d2);
            checkOutput("m_out_address", out_address, m_out.addr);
            checkOutput("m_out_immediate", out_immediate, m_out.imm);
            checkOutput("m_out_name", out_instr_name, m_out.name);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    task automatic applyStimulus(input bit valid, input logic [5:0] s1, input bit r1, input logic [31:0] d1,
                                 input logic [5:0] s2, input bit r2, input logic [31:0] d2, input logic [5:0] rrn);
        in_valid = valid;
        in_src_1 = s1; in_rdy_1 = r1; in_data_1 = d1;
        in_src_2 = s2; in_rdy_2 = r2; in_data_2 = d2;
        in_rrn = rrn;
        in_address = $urandom;
        in_immediate = $urandom;
        in_instr_name = instr_name_e'($urandom_range(0, 20));
    endtask

    task automatic setCdb(input bit valid, input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = valid; cdb_rrn = tag; cdb_data = data;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush = 1'b0;
        setCdb(1'b0, 6'd0, 32'd0);
    endtask

    logic [5:0] exp_order [4];

    initial begin
        // Reset state
        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_free_count", free_count, 4);
        checkOutput("rst_out_data_1", out_data_1, 0);
        checkOutput("rst_out_rrn", out_rrn, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            checkOutput("idle_free_count", free_count, 4);
            checkOutput("idle_out_valid", out_valid, 0);
        end

        // Ready insert: src_1 is x0, src_2 ready from regfile
        applyStimulus(1, 6'd0, 0, 32'hFFFF_FFFF, 6'd5, 1, 32'h55, 6'd7);
        tick();
        checkOutput("ins_same_edge", out_valid, 0);
        idle();
        tick();
        checkOutput("ready_valid", out_valid, 1);
        checkOutput("ready_data_1", out_data_1, 0);
        checkOutput("ready_data_2", out_data_2, 32'h55);
        checkOutput("ready_rrn", out_rrn, 7);
        out_ready = 1'b1;
        tick();
        checkOutput("ready_drained", out_valid, 0);

        // Wakeup from the CDB while waiting
        applyStimulus(1, 6'd9, 0, 32'h1234, 6'd0, 0, 32'h0, 6'd8);
        tick();
        idle();
        tick();
        setCdb(1, 6'd9, 32'hDEAD);
        tick();
        checkOutput("wake_capture_edge", out_valid, 0);
        setCdb(0, 6'd0, 32'd0);
        tick();
        checkOutput("wake_valid", out_valid, 1);
        checkOutput("wake_data_1", out_data_1, 32'hDEAD);
        checkOutput("wake_rrn", out_rrn, 8);

        // Same-cycle CDB at insert overrides the regfile value
        applyStimulus(1, 6'd12, 1, 32'h1111, 6'd0, 0, 32'h0, 6'd9);
        setCdb(1, 6'd12, 32'hBEEF);
        tick();
        idle();
        tick();
        checkOutput("samecdb_valid", out_valid, 1);
        checkOutput("samecdb_data_1", out_data_1, 32'hBEEF);
        tick();

        // Full and backpressure: the first instruction parks in the issue register
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 6'd0, 0, 32'h0, 6'd0, 0, 32'h0, 6'(16 + k));
            tick();
        end
        idle();
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_free_count", free_count, 0);
        repeat (2) begin
            tick();
            checkOutput("held_valid", out_valid, 1);
            checkOutput("held_rrn", out_rrn, 16);
        end
`ifdef RS_AGE_SELECT_EN
        exp_order = '{6'd17, 6'd18, 6'd19, 6'd20};
`else
        exp_order = '{6'd18, 6'd17, 6'd19, 6'd20};
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("drain_valid", out_valid, 1);
            checkOutput("drain_rrn", out_rrn, exp_order[k]);
            checkOutput("drain_in_ready", in_ready, 1);
        end
        tick();
        checkOutput("drain_done", out_valid, 0);

        // Flush with three waiting entries and a held issue
        out_ready = 1'b0;
        applyStimulus(1, 6'd0, 0, 32'h0, 6'd0, 0, 32'h0, 6'd24);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 6'(20 + k), 0, 32'h0, 6'd0, 0, 32'h0, 6'(25 + k));
            tick();
        end
        idle();
        checkOutput("preflush_valid", out_valid, 1);
        checkOutput("preflush_free", free_count, 1);
        flush = 1'b1;
        applyStimulus(1, 6'd0, 0, 32'h0, 6'd0, 0, 32'h0, 6'd28);
        setCdb(1, 6'd21, 32'h77);
        tick();
        idle();
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_free", free_count, 4);
        setCdb(1, 6'd20, 32'h99);
        tick();
        idle();
        repeat (2) begin
            tick();
            checkOutput("postflush_valid", out_valid, 0);
        end

        // Ordering: entry 2 is older than the entry reinserted at 0
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 6'(30 + k), 0, 32'h0, 6'd0, 0, 32'h0, 6'(40 + k));
            tick();
        end
        idle();
        setCdb(1, 6'd30, 32'hA);
        tick();
        setCdb(0, 6'd0, 32'd0);
        tick();
        checkOutput("order_first_out", out_rrn, 40);
        applyStimulus(1, 6'd32, 0, 32'h0, 6'd0, 0, 32'h0, 6'd43);
        tick();
        idle();
        setCdb(1, 6'd32, 32'hC);
        tick();
        idle();
        tick();
        checkOutput("order_valid", out_valid, 1);
`ifdef RS_AGE_SELECT_EN
        checkOutput("order_first", out_rrn, 42);
        tick();
        checkOutput("order_second", out_rrn, 43);
`else
        checkOutput("order_first", out_rrn, 43);
        tick();
        checkOutput("order_second", out_rrn, 42);
`endif
        flush = 1'b1;
        tick();
        idle();

        // Randomized traffic, with one asynchronous reset in the middle
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 99) < 60) && (m_free() != 0),
                          6'($urandom_range(0, 7)), $urandom_range(0, 99) < 30, $urandom,
                          6'($urandom_range(0, 7)), $urandom_range(0, 99) < 30, $urandom,
                          6'($urandom_range(1, 63)));
            setCdb($urandom_range(0, 99) < 40, 6'($urandom_range(0, 7)), $urandom);
            out_ready = $urandom_range(0, 99) < 60;
            flush = $urandom_range(0, 99) < 3;
            tick();
            if (c == 300) begin
                #2 reset_n = 1'b0;
                #1;
                checkOutput("async_rst_valid", out_valid, 0);
                checkOutput("async_rst_free", free_count, 4);
                checkOutput("async_rst_ready", in_ready, 1);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
